seg7_scan_driver: RTL and testbench

Time-multiplexed driver for a bank of N common-anode 7-segment digits sharing one segment bus. It holds a tear-free shadow copy of a packed BCD/hex word and scans one digit per refresh slot. Per digit it provides a decimal point, a forced blank, optional leading-zero suppression and a ghost-guard interval. It sits between the datapath registers and the board display pins.

---
 rtl/seg7_scan_driver.sv | 147 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a bank of common-anode
// 7-segment digits sharing one active-low segment bus. A shadow copy of the
// digit codes is only refreshed at frame boundaries so a frame never tears.
module seg7_scan_driver #(
   parameter int N_DIGITS    = 8,
   parameter int REFRESH_DIV = 100000,
   parameter int GHOST_CYC   = 1000,
   parameter bit HEX_MODE    = 1'b1
) (
   input  logic                    iClk,
   input  logic                    iRst,
   input  logic [4*N_DIGITS-1:0]   iData,
   input  logic [N_DIGITS-1:0]     iDp,
   input  logic [N_DIGITS-1:0]     iBlank,
   input  logic                    iLoad,
   input  logic                    iZeroSupp,
   output logic [6:0]              oSeg,
   output logic                    oDp,
   output logic [N_DIGITS-1:0]     oAn,
   output logic                    oFrame
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] GHOST_END = CW'(GHOST_CYC);
   localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

   logic [CW-1:0]           slotCnt;
   logic [IW-1:0]           digitIdx;
   logic [4*N_DIGITS-1:0]   shData;
   logic [N_DIGITS-1:0]     shDp;
   logic [N_DIGITS-1:0]     shBlank;
   logic                    loadPending;
   logic                    justWrapped;

   logic                    slotLast;
   logic                    frameEdge;

   logic [3:0]              codes [N_DIGITS];
   logic [N_DIGITS-1:0]     leadZero;
   logic                    zeroRun;
   logic                    suppressed;
   logic                    blankNow;
   logic [6:0]              segNext;
   logic                    dpNext;
   logic [N_DIGITS-1:0]     anNext;

   // Active-low {g,f,e,d,c,b,a} pattern for one digit code; letters only when HEX_MODE is set.
   function automatic logic [6:0] decodeDigit(input logic [3:0] code);
      logic [6:0] seg;
      case (code)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = HEX_MODE ? 7'b0001000 : 7'b1111111;
         4'hB:    seg = HEX_MODE ? 7'b0000011 : 7'b1111111;
         4'hC:    seg = HEX_MODE ? 7'b1000110 : 7'b1111111;
         4'hD:    seg = HEX_MODE ? 7'b0100001 : 7'b1111111;
         4'hE:    seg = HEX_MODE ? 7'b0000110 : 7'b1111111;
         4'hF:    seg = HEX_MODE ? 7'b0001110 : 7'b1111111;
         default: seg = 7'b1111111;
      endcase
      return seg;
   endfunction

   assign slotLast  = (slotCnt == SLOT_LAST);
   assign frameEdge = slotLast && (digitIdx == IDX_LAST);

   // Scan position, shadow capture at the frame boundary, and load-request merging.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         slotCnt     <= '0;
         digitIdx    <= '0;
         shData      <= '0;
         shDp        <= '0;
         shBlank     <= '0;
         loadPending <= 1'b0;
         justWrapped <= 1'b0;
      end else begin
         justWrapped <= frameEdge;

         if (slotLast) begin
            slotCnt  <= '0;
            digitIdx <= (digitIdx == IDX_LAST) ? '0 : digitIdx + 1'b1;
         end else begin
            slotCnt <= slotCnt + 1'b1;
         end

         if (frameEdge && (loadPending || iLoad)) begin
            shData      <= iData;
            shDp        <= iDp;
            shBlank     <= iBlank;
            loadPending <= 1'b0;
         end else if (iLoad) begin
            loadPending <= 1'b1;
         end
      end
   end

   // Next-cycle segment, decimal point and anode values for the digit currently in its slot.
   always_comb begin
      zeroRun    = 1'b1;
      leadZero   = '0;
      for (int k = 0; k < N_DIGITS; k++) begin
         codes[k] = shData[4*k +: 4];
      end
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         zeroRun     = zeroRun && (codes[k] == 4'h0);
         leadZero[k] = zeroRun;
      end

      suppressed = iZeroSupp && (digitIdx != '0) && leadZero[digitIdx];
      blankNow   = shBlank[digitIdx] || suppressed;
      segNext    = blankNow ? 7'h7F : decodeDigit(codes[digitIdx]);
      dpNext     = shBlank[digitIdx] ? 1'b1 : ~shDp[digitIdx];

      anNext = '1;
      if (slotCnt >= GHOST_END) begin
         anNext[digitIdx] = 1'b0;
      end
   end

   // Registered pin drivers; oFrame lines up with the first output cycle of digit 0.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         oSeg   <= 7'h7F;
         oDp    <= 1'b1;
         oAn    <= '1;
         oFrame <= 1'b0;
      end else begin
         oSeg   <= segNext;
         oDp    <= dpNext;
         oAn    <= anNext;
         oFrame <= justWrapped;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed, table-driven checks of the scan driver with
// 4 digits, 4-cycle slots and a 1-cycle ghost guard, plus a HEX_MODE=0 twin.
module tb_seg7_scan_driver;

   localparam logic [6:0] S0  = 7'b1000000;
   localparam logic [6:0] S1  = 7'b1111001;
   localparam logic [6:0] S2  = 7'b0100100;
   localparam logic [6:0] S4  = 7'b0011001;
   localparam logic [6:0] S5  = 7'b0010010;
   localparam logic [6:0] S6  = 7'b0000010;
   localparam logic [6:0] S8  = 7'b0000000;
   localparam logic [6:0] S9  = 7'b0010000;
   localparam logic [6:0] SA  = 7'b0001000;
   localparam logic [6:0] SB  = 7'b0000011;
   localparam logic [6:0] SC  = 7'b1000110;
   localparam logic [6:0] SD  = 7'b0100001;
   localparam logic [6:0] SE  = 7'b0000110;
   localparam logic [6:0] SF  = 7'b0001110;
   localparam logic [6:0] SBL = 7'b1111111;

   typedef struct {
      logic [15:0] data;
      logic [3:0]  dp;
      logic [3:0]  blank;
      logic        zs;
      logic [27:0] segs;
      logic [27:0] segsH0;
      logic [3:0]  expDp;
   } vec_t;

   logic        iClk = 1'b0;
   logic        iRst;
   logic [15:0] iData;
   logic [3:0]  iDp;
   logic [3:0]  iBlank;
   logic        iLoad;
   logic        iZeroSupp;
   logic [6:0]  oSeg;
   logic        oDp;
   logic [3:0]  oAn;
   logic        oFrame;
   logic [6:0]  seg0;
   logic        dp0;
   logic [3:0]  an0;
   logic        frame0;

   int vectorCount = 0;
   int miscompares = 0;

   vec_t vecs [8];

   // 10 ns clock.
   always #5 iClk = ~iClk;

   seg7_scan_driver #(
      .N_DIGITS(4), .REFRESH_DIV(4), .GHOST_CYC(1), .HEX_MODE(1'b1)
   ) dut (
      .iClk(iClk), .iRst(iRst), .iData(iData), .iDp(iDp), .iBlank(iBlank),
      .iLoad(iLoad), .iZeroSupp(iZeroSupp),
      .oSeg(oSeg), .oDp(oDp), .oAn(oAn), .oFrame(oFrame)
   );

   seg7_scan_driver #(
      .N_DIGITS(4), .REFRESH_DIV(4), .GHOST_CYC(1), .HEX_MODE(1'b0)
   ) dutHex0 (
      .iClk(iClk), .iRst(iRst), .iData(iData), .iDp(iDp), .iBlank(iBlank),
      .iLoad(iLoad), .iZeroSupp(iZeroSupp),
      .oSeg(seg0), .oDp(dp0), .oAn(an0), .oFrame(frame0)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectorCount++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] data, input logic [3:0] dp,
                                input logic [3:0] blank, input logic zs);
      iData     = data;
      iDp       = dp;
      iBlank    = blank;
      iZeroSupp = zs;
      iLoad     = 1'b1;
      @(negedge iClk);
      iLoad = 1'b0;
      @(negedge iClk);
   endtask

   task automatic waitFrame(input string tag);
      bit found;
      found = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (oFrame === 1'b1) begin
            found = 1'b1;
            break;
         end
         @(negedge iClk);
      end
      if (!found) checkOutput({tag, " frame timeout"}, 32'd0, 32'd1);
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, " an"}, oAn, 4'hF);
      checkOutput({tag, " seg"}, oSeg, 7'h7F);
      checkOutput({tag, " dp"}, oDp, 1'b1);
      checkOutput({tag, " frame"}, oFrame, 1'b0);
   endtask

   task automatic checkCycle(input int j, input logic [27:0] segs, input logic [27:0] segsH0,
                             input logic [3:0] expDp, input string tag);
      int digit;
      bit lit;
      logic [3:0] anExp;
      string nm;
      digit = j / 4;
      lit   = (j % 4) != 0;
      anExp = 4'hF;
      if (lit) anExp[digit] = 1'b0;
      nm = $sformatf("%s j%0d", tag, j);
      checkOutput({nm, " an"}, oAn, anExp);
      checkOutput({nm, " frame"}, oFrame, (j == 0));
      checkOutput({nm, " hex0 an"}, an0, anExp);
      checkOutput({nm, " hex0 frame"}, frame0, (j == 0));
      if (lit) begin
         checkOutput({nm, " seg"}, oSeg, segs[digit*7 +: 7]);
         checkOutput({nm, " dp"}, oDp, expDp[digit]);
         checkOutput({nm, " hex0 seg"}, seg0, segsH0[digit*7 +: 7]);
         checkOutput({nm, " hex0 dp"}, dp0, expDp[digit]);
      end
   endtask

   task automatic runFrame(input logic [27:0] segs, input logic [27:0] segsH0,
                           input logic [3:0] expDp, input int loadJ,
                           input logic [15:0] newData, input string tag);
      for (int j = 0; j < 16; j++) begin
         checkCycle(j, segs, segsH0, expDp, tag);
         if (j == loadJ) begin
            iData = newData;
            iLoad = 1'b1;
         end else begin
            iLoad = 1'b0;
         end
         @(negedge iClk);
      end
      iLoad = 1'b0;
   endtask

   // Hang guard.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before 100000 ns");
      $fatal(1, "[TB] simulation timeout");
   end

   // Main sequence.
   initial begin
      logic [3:0] anSeq [6];

      vecs[0] = '{16'h9A05, 4'b0000, 4'b0000, 1'b0, {S9, SA, S0, S5}, {S9, SBL, S0, S5}, 4'b1111};
      vecs[1] = '{16'h0040, 4'b0000, 4'b0000, 1'b1, {SBL, SBL, S4, S0}, {SBL, SBL, S4, S0}, 4'b1111};
      vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, {SBL, SBL, SBL, S0}, {SBL, SBL, SBL, S0}, 4'b1111};
      vecs[3] = '{16'h0040, 4'b0000, 4'b0000, 1'b0, {S0, S0, S4, S0}, {S0, S0, S4, S0}, 4'b1111};
      vecs[4] = '{16'h8765, 4'b0110, 4'b0100, 1'b0, {S8, SBL, S6, S5}, {S8, SBL, S6, S5}, 4'b1101};
      vecs[5] = '{16'hBCDE, 4'b1001, 4'b0000, 1'b0, {SB, SC, SD, SE}, {SBL, SBL, SBL, SBL}, 4'b0110};
      vecs[6] = '{16'h0F00, 4'b1000, 4'b0000, 1'b1, {SBL, SF, S0, S0}, {SBL, SBL, S0, S0}, 4'b0111};
      vecs[7] = '{16'h1234, 4'b1111, 4'b1111, 1'b0, {SBL, SBL, SBL, SBL}, {SBL, SBL, SBL, SBL}, 4'b1111};

      anSeq = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD};

      iRst      = 1'b1;
      iData     = 16'h1234;
      iDp       = 4'b0000;
      iBlank    = 4'b0000;
      iLoad     = 1'b0;
      iZeroSupp = 1'b0;

      $display("[TB] reset hold");
      for (int k = 0; k < 3; k++) begin
         @(negedge iClk);
         checkReset($sformatf("reset hold %0d", k));
      end
      iRst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge iClk);
         checkOutput($sformatf("post-reset an %0d", k), oAn, anSeq[k]);
         if (k == 1) checkOutput("post-reset digit0 seg", oSeg, S0);
      end

      $display("[TB] table vectors");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].data, vecs[i].dp, vecs[i].blank, vecs[i].zs);
         waitFrame($sformatf("vec%0d", i));
         runFrame(vecs[i].segs, vecs[i].segsH0, vecs[i].expDp, -1, 16'h0000,
                  $sformatf("vec%0d", i));
      end

      $display("[TB] tear-free load and load on boundary edge");
      applyStimulus(16'h9A05, 4'b0000, 4'b0000, 1'b0);
      waitFrame("tear");
      runFrame({S9, SA, S0, S5}, {S9, SBL, S0, S5}, 4'b1111, 5, 16'h1111, "tear old");
      runFrame({S1, S1, S1, S1}, {S1, S1, S1, S1}, 4'b1111, 14, 16'h2222, "tear new");
      checkOutput("boundary load frame", oFrame, 1'b1);

      $display("[TB] reset mid-frame with pending load");
      for (int j = 0; j < 10; j++) begin
         checkCycle(j, {S2, S2, S2, S2}, {S2, S2, S2, S2}, 4'b1111, "boundary load");
         if (j == 5) begin
            iData = 16'h3333;
            iLoad = 1'b1;
         end else begin
            iLoad = 1'b0;
         end
         if (j < 9) @(negedge iClk);
      end
      iRst = 1'b1;
      @(negedge iClk);
      checkReset("mid-frame reset");
      iRst = 1'b0;
      waitFrame("after reset");
      runFrame({S0, S0, S0, S0}, {S0, S0, S0, S0}, 4'b1111, -1, 16'h3333, "after reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
      $finish;
   end

endmodule
